// File: rtl/coherence_pkg.sv
// Shared definitions for the MSI home-node directory.
//   - 3-bit message codes exchanged between caches and the directory
//   - 2-bit directory entry state codes
//   - controller FSM state enum
package coherence_pkg;

  localparam logic [2:0] MSG_READ_MISS  = 3'b000;
  localparam logic [2:0] MSG_READ_HIT   = 3'b001;
  localparam logic [2:0] MSG_WRITE_HIT  = 3'b010;
  localparam logic [2:0] MSG_INVAL      = 3'b011;
  localparam logic [2:0] MSG_WRITE_MISS = 3'b100;
  localparam logic [2:0] MSG_FETCH      = 3'b101;
  localparam logic [2:0] MSG_FETCH_INV  = 3'b110;
  localparam logic [2:0] MSG_EMPTY      = 3'b111;

  localparam logic [1:0] DIR_UNCACHED = 2'b00;
  localparam logic [1:0] DIR_SHARED   = 2'b01;
  localparam logic [1:0] DIR_EXCL     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INVAL,
    ST_FETCH,
    ST_WAIT_WB,
    ST_REPLY
  } ctl_state_t;

endpackage

// File: rtl/dir_sharer_scan.sv
// Combinational lowest-set-bit finder over a sharer vector.
//   vec   : NODES-bit sharer vector
//   idx   : index of the lowest set bit (0 when none)
//   found : high when at least one bit of vec is set
module dir_sharer_scan #(
  parameter int NODES = 4,
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic [NODES-1:0] vec,
  output logic [NW-1:0]    idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = NW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_directory.sv
// MSI home-node directory controller.
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only while idle)
//   req_acao/req_node/req_block: miss type, requesting cache, block
//   escrita/msg_node/msg_block : invalidate / fetch / fetch-invalidate to a cache
//   wb_valid                   : owner write-back strobe, honoured only in WAIT_WB
//   reply_valid/node/block     : one-cycle data reply to the requester
module coherence_directory
  import coherence_pkg::*;
#(
  parameter int NODES  = 4,
  parameter int BLOCKS = 4,
  localparam int NW = (NODES  > 1) ? $clog2(NODES)  : 1,
  localparam int BW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_acao,
  input  logic [NW-1:0] req_node,
  input  logic [BW-1:0] req_block,
  output logic [2:0]    escrita,
  output logic [NW-1:0] msg_node,
  output logic [BW-1:0] msg_block,
  input  logic          wb_valid,
  output logic          reply_valid,
  output logic [NW-1:0] reply_node,
  output logic [BW-1:0] reply_block
);

  function automatic logic [NODES-1:0] node_bit(input logic [NW-1:0] n);
    node_bit = NODES'(1) << n;
  endfunction

  ctl_state_t       state, next_state;
  logic [1:0]       dir_state   [BLOCKS];
  logic [NODES-1:0] dir_sharers [BLOCKS];

  logic [2:0]       lat_acao;
  logic [NW-1:0]    lat_node;
  logic [BW-1:0]    lat_block;
  logic [NODES-1:0] pend, n_pend;

  logic [2:0]       n_escrita;
  logic [NW-1:0]    n_msg_node, n_reply_node;
  logic [BW-1:0]    n_msg_block, n_reply_block;
  logic             n_reply;

  logic [1:0]       cur_state;
  logic [NODES-1:0] cur_sharers, others, scan_vec;
  logic [NW-1:0]    owner_idx, inv_idx;
  logic             owner_found, inv_found, owner_hit, is_miss;

  assign req_ready   = (state == ST_IDLE);
  assign cur_state   = dir_state[req_block];
  assign cur_sharers = dir_sharers[req_block];
  assign others      = cur_sharers & ~node_bit(req_node);
  assign owner_hit   = owner_found && (owner_idx == req_node);
  assign is_miss     = (req_acao == MSG_READ_MISS) || (req_acao == MSG_WRITE_MISS);
  // While idle the invalidate scanner looks at the candidate set of the
  // incoming request; during INVAL it walks the still-pending sharers.
  assign scan_vec    = (state == ST_IDLE) ? others : pend;

  dir_sharer_scan #(.NODES(NODES)) u_owner_scan (
    .vec   (cur_sharers),
    .idx   (owner_idx),
    .found (owner_found)
  );

  dir_sharer_scan #(.NODES(NODES)) u_inval_scan (
    .vec   (scan_vec),
    .idx   (inv_idx),
    .found (inv_found)
  );

  // Outputs are registered from next-cycle values so every message and
  // reply appears in the cycle that its state occupies.
  always_comb begin
    next_state    = state;
    n_escrita     = MSG_EMPTY;
    n_msg_node    = msg_node;
    n_msg_block   = msg_block;
    n_reply_node  = reply_node;
    n_reply_block = reply_block;
    n_pend        = pend;
    unique case (state)
      ST_IDLE: begin
        if (req_valid && is_miss) begin
          if (cur_state == DIR_EXCL && !owner_hit) begin
            next_state  = ST_FETCH;
            n_escrita   = (req_acao == MSG_READ_MISS) ? MSG_FETCH : MSG_FETCH_INV;
            n_msg_node  = owner_idx;
            n_msg_block = req_block;
          end else if (cur_state == DIR_SHARED && req_acao == MSG_WRITE_MISS && inv_found) begin
            next_state  = ST_INVAL;
            n_escrita   = MSG_INVAL;
            n_msg_node  = inv_idx;
            n_msg_block = req_block;
            n_pend      = others & ~node_bit(inv_idx);
          end else begin
            next_state = ST_REPLY;
          end
        end
      end
      ST_INVAL: begin
        if (inv_found) begin
          n_escrita   = MSG_INVAL;
          n_msg_node  = inv_idx;
          n_msg_block = lat_block;
          n_pend      = pend & ~node_bit(inv_idx);
        end else begin
          next_state = ST_REPLY;
        end
      end
      ST_FETCH:   next_state = ST_WAIT_WB;
      ST_WAIT_WB: if (wb_valid) next_state = ST_REPLY;
      ST_REPLY:   next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    n_reply = (next_state == ST_REPLY);
    if (n_reply) begin
      n_reply_node  = (state == ST_IDLE) ? req_node  : lat_node;
      n_reply_block = (state == ST_IDLE) ? req_block : lat_block;
    end
  end

  // Control state, registered outputs and directory entries
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      escrita     <= MSG_EMPTY;
      msg_node    <= '0;
      msg_block   <= '0;
      reply_valid <= 1'b0;
      reply_node  <= '0;
      reply_block <= '0;
      for (int b = 0; b < BLOCKS; b++) begin
        dir_state[b]   <= DIR_UNCACHED;
        dir_sharers[b] <= '0;
      end
    end else begin
      state       <= next_state;
      escrita     <= n_escrita;
      msg_node    <= n_msg_node;
      msg_block   <= n_msg_block;
      reply_valid <= n_reply;
      reply_node  <= n_reply_node;
      reply_block <= n_reply_block;
      if (state == ST_REPLY) begin
        if (lat_acao == MSG_WRITE_MISS) begin
          dir_state[lat_block]   <= DIR_EXCL;
          dir_sharers[lat_block] <= node_bit(lat_node);
        end else if (!(dir_state[lat_block] == DIR_EXCL &&
                       dir_sharers[lat_block] == node_bit(lat_node))) begin
          // Read miss: owner re-reads leave the entry alone, everyone else
          // joins the sharer set (a previous owner stays in it).
          dir_state[lat_block]   <= DIR_SHARED;
          dir_sharers[lat_block] <= dir_sharers[lat_block] | node_bit(lat_node);
        end
      end
    end
  end

  // Request latch and pending-invalidate vector
  always_ff @(posedge clock) begin
    pend <= n_pend;
    if (state == ST_IDLE && req_valid) begin
      lat_acao  <= req_acao;
      lat_node  <= req_node;
      lat_block <= req_block;
    end
  end

endmodule

// File: doc/coherence_directory.md
# coherence_directory

Home-node directory controller for the MSI coherence protocol. It is the responder to the per-cache `state_machine` controllers. It accepts read-miss and write-miss requests from the caches and keeps one directory entry per memory block: a state and a sharer vector. Before granting a block it issues invalidate, fetch and fetch-invalidate messages to the caches and collects their data write-backs. It sits between the cache interconnect and memory.

## Interface
Clock: one clock; reset is synchronous and active-high.

Parameters:
- NODES, 4, number of caches; node ids are 0..NODES-1.
- BLOCKS, 4, number of directory entries; block ids are 0..BLOCKS-1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_acao  in  3  000 read miss, 100 write miss; other codes are accepted and ignored.
- req_node  in  $clog2(NODES)  requesting cache.
- req_block  in  $clog2(BLOCKS)  requested block.
- escrita  out  3  message to a cache: 011 invalidate, 101 fetch, 110 fetch invalidate, 111 empty.
- msg_node  out  $clog2(NODES)  destination of `escrita`.
- msg_block  out  $clog2(BLOCKS)  block addressed by `escrita`.
- wb_valid  in  1  owner's `dataWriteBack` is present.
- reply_valid  out  1  one-cycle data-reply pulse.
- reply_node  out  $clog2(NODES)  reply destination.
- reply_block  out  $clog2(BLOCKS)  reply block.

## Operation
- Entry state encoding: 00 uncached, 01 shared, 10 exclusive. Each entry also holds a NODES-bit sharer vector; in exclusive it is one-hot and marks the owner.
- Controller FSM states:
  - IDLE
  - INVAL: one invalidate per cycle to the remaining sharers, in ascending node order, requester excluded.
  - FETCH: one cycle, sends fetch or fetch invalidate to the owner.
  - WAIT_WB: holds until `wb_valid`.
  - REPLY: one cycle, pulses the reply and updates the entry.
- A request is accepted on `req_valid && req_ready`. The acao, node and block are latched.
- Transitions per entry:
  - Uncached, read miss: shared, sharers = {req}, reply.
  - Uncached, write miss: exclusive, sharers = {req}, reply.
  - Shared, read miss: add req to sharers, reply.
  - Shared, write miss: INVAL over sharers & ~req, then exclusive, sharers = {req}, reply. With no other sharers, go directly to REPLY.
  - Exclusive, read miss from a non-owner: fetch (101) to the owner, wait for write-back, then shared, sharers = {owner, req}, reply.
  - Exclusive, write miss from a non-owner: fetch invalidate (110) to the owner, wait for write-back, then exclusive, sharers = {req}, reply.
  - Exclusive, any miss from the owner itself: reply, entry unchanged.
  - Any other acao: back to IDLE with no message and no reply.
- `wb_valid` is sampled only in WAIT_WB and is ignored in every other state.
- Reset values: all entries uncached with sharers = 0, FSM in IDLE, `escrita` = 111, `msg_node` = 0, `msg_block` = 0, `reply_valid` = 0, `reply_node` = 0, `reply_block` = 0.
- Reset mid-transaction aborts the transaction. No reply is issued and the entry is cleared.

## Timing
- All outputs are registered except `req_ready`, which is decoded from state == IDLE.
- Request accepted at edge N:
  - Uncached, shared read, or owner miss: `reply_valid` high in cycle N+1.
  - Shared write miss with k other sharers: invalidates in cycles N+1..N+k, reply in cycle N+k+1.
  - Exclusive, non-owner: 101 or 110 in cycle N+1. If `wb_valid` is first sampled at edge M, the reply is in cycle M+1.
- `escrita` reads 111 in every cycle that carries no message.
- The reply and a message are never issued in the same cycle.
- The entry update becomes visible to the next request, which is accepted no earlier than the cycle after REPLY.
- `wb_valid` asserted in the same cycle the fetch is issued is not counted. The earliest valid write-back is cycle N+2.

## Structure
- Shared package `coherence_pkg` holds:
  - the 3-bit message codes (read miss, read hit, write hit, invalidate, write miss, fetch, fetch invalidate, empty);
  - the 2-bit directory state codes;
  - the controller FSM state enum.
- Sub-module `dir_sharer_scan`: combinational lowest-set-bit finder over a NODES-bit vector, returning index and found flag. It is used by INVAL and to extract the owner.

## Test plan
- Reset, then read miss from node 1 to block 2 → reply to (1,2) in cycle N+1; entry becomes shared with sharers 0010; `escrita` stays 111.
- Read misses from nodes 0, 1 and 3 to block 0, then write miss from node 1 → invalidates to nodes 0 then 3 in consecutive cycles; reply to node 1 on the following cycle; entry exclusive, sharers 0010.
- Block 3 exclusive at node 2, read miss from node 0 → fetch (101) to node 2; `wb_valid` held low 3 cycles, then pulsed → reply to node 0 one cycle later; entry shared, sharers 0101.
- Block 3 exclusive at node 2, write miss from node 1 → fetch invalidate (110) to node 2; reply after write-back; sharers 0010. A stray `wb_valid` while in IDLE leaves the entry unchanged.
- Reset asserted in WAIT_WB → no reply; all entries uncached; `req_ready` high in the first cycle after reset.
- `req_acao` = 010 → accepted, no message, no reply, entry unchanged; `req_ready` low while any transaction is in progress.
